mesi_isc_cpu_agent: RTL and testbench

- Per-CPU coherence agent sitting directly upstream of the coherence controller. One instance per CPU port (0..3).
- Converts CPU load/store requests into main-bus broadcast commands (mbus_cmd/mbus_addr, held until mbus_ack).
- Consumes the controller's coherence-bus commands (cbus_cmd/cbus_addr) and answers each with cbus_ack after a fixed snoop latency.
- Keeps a small direct-mapped MESI tag/state table.

---
 rtl/mesi_isc_pkg.sv | 47 ++++
 rtl/mesi_isc_cpu_agent_snoop.sv | 87 ++++++++
 rtl/mesi_isc_cpu_agent.sv | 218 +++++++++++++++++++++
 tb/tb_mesi_isc_cpu_agent.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_isc_pkg.sv
// Shared command encodings, MESI line states and FSM state types for the
// per-CPU coherence agent.
package mesi_isc_pkg;

   typedef enum logic [2:0] {
      MBUS_NOP      = 3'd0,
      MBUS_WR       = 3'd1,
      MBUS_RD       = 3'd2,
      MBUS_WR_BROAD = 3'd3,
      MBUS_RD_BROAD = 3'd4
   } mbus_cmd_t;

   typedef enum logic [2:0] {
      CBUS_NOP      = 3'd0,
      CBUS_WR_SNOOP = 3'd1,
      CBUS_RD_SNOOP = 3'd2,
      CBUS_EN_WR    = 3'd3,
      CBUS_EN_RD    = 3'd4
   } cbus_cmd_t;

   typedef enum logic [1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_state_t;

   typedef enum logic [1:0] {
      MAIN_IDLE    = 2'd0,
      MAIN_MREQ    = 2'd1,
      MAIN_WAIT_EN = 2'd2,
      MAIN_DONE    = 2'd3
   } main_state_t;

   typedef enum logic [1:0] {
      SN_IDLE = 2'd0,
      SN_WAIT = 2'd1,
      SN_ACK  = 2'd2,
      SN_GAP  = 2'd3
   } snoop_state_t;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/mesi_isc_cpu_agent_snoop.sv
// Coherence-bus snoop sequencer: captures one command, acks it after a fixed
// latency, then ignores the bus for one cycle so a held command is acked once.
module mesi_isc_cpu_agent_snoop
   import mesi_isc_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int CBUS_CMD_WIDTH = 3,
   parameter int SNOOP_LAT      = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
   input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
   output logic [CBUS_CMD_WIDTH-1:0] snp_cmd_o,
   output logic [ADDR_WIDTH-1:0]     snp_addr_o,
   output logic                      ack_o,
   output logic                      ack_next_o
);

   snoop_state_t              sn_state_r;
   logic [3:0]                cnt_r;
   logic [CBUS_CMD_WIDTH-1:0] cmd_r;
   logic [ADDR_WIDTH-1:0]     addr_r;
   logic                      ack_r;
   logic                      ack_next_s;

   // Snoop FSM with latency counter and registered ack strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sn_state_r <= SN_IDLE;
         cnt_r      <= 4'd0;
         cmd_r      <= {CBUS_CMD_WIDTH{1'b0}};
         addr_r     <= {ADDR_WIDTH{1'b0}};
         ack_r      <= 1'b0;
      end else begin
         case (sn_state_r)
            SN_IDLE: begin
               if (cbus_cmd_i != CBUS_CMD_WIDTH'(CBUS_NOP)) begin
                  cmd_r  <= cbus_cmd_i;
                  addr_r <= cbus_addr_i;
                  cnt_r  <= 4'(SNOOP_LAT - 1);
                  if (SNOOP_LAT == 1) begin
                     sn_state_r <= SN_ACK;
                     ack_r      <= 1'b1;
                  end else begin
                     sn_state_r <= SN_WAIT;
                  end
               end
            end
            SN_WAIT: begin
               cnt_r <= cnt_r - 4'd1;
               if (cnt_r == 4'd1) begin
                  sn_state_r <= SN_ACK;
                  ack_r      <= 1'b1;
               end
            end
            SN_ACK: begin
               ack_r      <= 1'b0;
               sn_state_r <= SN_GAP;
            end
            SN_GAP: begin
               sn_state_r <= SN_IDLE;
            end
            default: begin
               ack_r      <= 1'b0;
               sn_state_r <= SN_IDLE;
            end
         endcase
      end
   end

   // Look-ahead of the ack so the CPU side can drop ready in time
   always_comb begin
      ack_next_s = 1'b0;
      case (sn_state_r)
         SN_IDLE: ack_next_s = (cbus_cmd_i != CBUS_CMD_WIDTH'(CBUS_NOP)) && (SNOOP_LAT == 1);
         SN_WAIT: ack_next_s = (cnt_r == 4'd1);
         default: ack_next_s = 1'b0;
      endcase
   end

   assign snp_cmd_o  = cmd_r;
   assign snp_addr_o = addr_r;
   assign ack_o      = ack_r;
   assign ack_next_o = ack_next_s;

endmodule

// File: rtl/mesi_isc_cpu_agent.sv
// Per-CPU MESI agent: CPU request FSM, direct-mapped tag/state table, snoop glue.
// Optional statistics counters under `MESI_ISC_CPU_AGENT_STATS_EN.
module mesi_isc_cpu_agent
   import mesi_isc_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int MBUS_CMD_WIDTH = 3,
   parameter int CBUS_CMD_WIDTH = 3,
   parameter int NUM_LINES      = 4,
   parameter int IDX_W          = 2,
   parameter int SNOOP_LAT      = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid_i,
   input  logic                      req_wr_i,
   input  logic [ADDR_WIDTH-1:0]     req_addr_i,
   output logic                      req_ready_o,
   output logic                      resp_valid_o,
   output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
   output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
   input  logic                      mbus_ack_i,
   input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
   input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
`ifdef MESI_ISC_CPU_AGENT_STATS_EN
   output logic [15:0]               stat_hit_o,
   output logic [15:0]               stat_miss_o,
   output logic [15:0]               stat_inv_o,
`endif
   output logic                      cbus_ack_o
);

   localparam int TAG_W = ADDR_WIDTH - IDX_W;

   main_state_t           main_state_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic                  wr_r;
   mbus_cmd_t             mbus_cmd_r;
   logic [ADDR_WIDTH-1:0] mbus_addr_r;
   logic                  resp_valid_r;
   logic                  req_ready_r;

   mesi_state_t           line_state_r [NUM_LINES];
   logic [TAG_W-1:0]      line_tag_r   [NUM_LINES];

   logic [CBUS_CMD_WIDTH-1:0] sn_cmd_s;
   logic [ADDR_WIDTH-1:0]     sn_addr_s;
   logic                      sn_ack_s;
   logic                      sn_ack_next_s;

   mesi_isc_cpu_agent_snoop #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .CBUS_CMD_WIDTH(CBUS_CMD_WIDTH),
      .SNOOP_LAT     (SNOOP_LAT)
   ) u_snoop (
      .clk        (clk),
      .rst        (rst),
      .cbus_cmd_i (cbus_cmd_i),
      .cbus_addr_i(cbus_addr_i),
      .snp_cmd_o  (sn_cmd_s),
      .snp_addr_o (sn_addr_s),
      .ack_o      (sn_ack_s),
      .ack_next_o (sn_ack_next_s)
   );

   logic [IDX_W-1:0] req_idx_s;
   logic [TAG_W-1:0] req_tag_s;
   mesi_state_t      req_line_st_s;
   logic             req_hit_s;
   logic             fast_s;
   logic             accept_s;
   logic [IDX_W-1:0] sn_idx_s;
   logic [TAG_W-1:0] sn_tag_s;
   mesi_state_t      sn_line_st_s;
   logic             sn_hit_s;
   logic             en_match_s;

   assign req_idx_s     = req_addr_i[IDX_W-1:0];
   assign req_tag_s     = req_addr_i[ADDR_WIDTH-1:IDX_W];
   assign req_line_st_s = line_state_r[req_idx_s];
   assign req_hit_s     = (req_line_st_s != MESI_I) && (line_tag_r[req_idx_s] == req_tag_s);
   // Loads hit on any valid state; stores only complete locally on E/M.
   assign fast_s        = req_hit_s && (!req_wr_i || (req_line_st_s == MESI_E) || (req_line_st_s == MESI_M));
   assign accept_s      = req_valid_i && req_ready_r;

   assign sn_idx_s      = sn_addr_s[IDX_W-1:0];
   assign sn_tag_s      = sn_addr_s[ADDR_WIDTH-1:IDX_W];
   assign sn_line_st_s  = line_state_r[sn_idx_s];
   assign sn_hit_s      = (sn_line_st_s != MESI_I) && (line_tag_r[sn_idx_s] == sn_tag_s);
   assign en_match_s    = (main_state_r == MAIN_WAIT_EN) && (sn_addr_s == addr_r) &&
                          ((wr_r && (sn_cmd_s == CBUS_CMD_WIDTH'(CBUS_EN_WR))) ||
                           (!wr_r && (sn_cmd_s == CBUS_CMD_WIDTH'(CBUS_EN_RD))));

   // CPU request FSM with registered handshake and main-bus outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_state_r <= MAIN_IDLE;
         addr_r       <= {ADDR_WIDTH{1'b0}};
         wr_r         <= 1'b0;
         mbus_cmd_r   <= MBUS_NOP;
         mbus_addr_r  <= {ADDR_WIDTH{1'b0}};
         resp_valid_r <= 1'b0;
         req_ready_r  <= 1'b0;
      end else begin
         case (main_state_r)
            MAIN_IDLE: begin
               if (accept_s) begin
                  addr_r      <= req_addr_i;
                  wr_r        <= req_wr_i;
                  req_ready_r <= 1'b0;
                  if (fast_s) begin
                     main_state_r <= MAIN_DONE;
                     resp_valid_r <= 1'b1;
                  end else begin
                     main_state_r <= MAIN_MREQ;
                     mbus_cmd_r   <= req_wr_i ? MBUS_WR_BROAD : MBUS_RD_BROAD;
                     mbus_addr_r  <= req_addr_i;
                  end
               end else begin
                  req_ready_r <= !sn_ack_next_s;
               end
            end
            MAIN_MREQ: begin
               if (mbus_ack_i) begin
                  mbus_cmd_r   <= MBUS_NOP;
                  main_state_r <= MAIN_WAIT_EN;
               end
            end
            MAIN_WAIT_EN: begin
               if (sn_ack_s && en_match_s) begin
                  main_state_r <= MAIN_DONE;
                  resp_valid_r <= 1'b1;
               end
            end
            MAIN_DONE: begin
               resp_valid_r <= 1'b0;
               main_state_r <= MAIN_IDLE;
               req_ready_r  <= !sn_ack_next_s;
            end
            default: begin
               main_state_r <= MAIN_IDLE;
               mbus_cmd_r   <= MBUS_NOP;
               resp_valid_r <= 1'b0;
               req_ready_r  <= 1'b0;
            end
         endcase
      end
   end

   // Tag/state table: snoop updates on the ack cycle, local store-hit upgrade otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_LINES; i++) begin
            line_state_r[i] <= MESI_I;
            line_tag_r[i]   <= {TAG_W{1'b0}};
         end
      end else if (sn_ack_s) begin
         case (sn_cmd_s)
            CBUS_CMD_WIDTH'(CBUS_WR_SNOOP): begin
               if (sn_hit_s) begin
                  line_state_r[sn_idx_s] <= MESI_I;
               end
            end
            CBUS_CMD_WIDTH'(CBUS_RD_SNOOP): begin
               if (sn_hit_s && ((sn_line_st_s == MESI_E) || (sn_line_st_s == MESI_M))) begin
                  line_state_r[sn_idx_s] <= MESI_S;
               end
            end
            CBUS_CMD_WIDTH'(CBUS_EN_WR), CBUS_CMD_WIDTH'(CBUS_EN_RD): begin
               if (en_match_s) begin
                  line_tag_r[sn_idx_s]   <= sn_tag_s;
                  line_state_r[sn_idx_s] <= wr_r ? MESI_M : MESI_S;
               end
            end
            default: begin
            end
         endcase
      end else if (accept_s && fast_s && req_wr_i) begin
         line_state_r[req_idx_s] <= MESI_M;
      end
   end

`ifdef MESI_ISC_CPU_AGENT_STATS_EN
   logic [15:0] stat_hit_r;
   logic [15:0] stat_miss_r;
   logic [15:0] stat_inv_r;

   // Saturating event counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_hit_r  <= 16'd0;
         stat_miss_r <= 16'd0;
         stat_inv_r  <= 16'd0;
      end else begin
         if (accept_s && fast_s) begin
            stat_hit_r <= sat_inc(stat_hit_r);
         end
         if (accept_s && !fast_s) begin
            stat_miss_r <= sat_inc(stat_miss_r);
         end
         if (sn_ack_s && (sn_cmd_s == CBUS_CMD_WIDTH'(CBUS_WR_SNOOP)) && sn_hit_s) begin
            stat_inv_r <= sat_inc(stat_inv_r);
         end
      end
   end

   assign stat_hit_o  = stat_hit_r;
   assign stat_miss_o = stat_miss_r;
   assign stat_inv_o  = stat_inv_r;
`endif

   assign req_ready_o  = req_ready_r;
   assign resp_valid_o = resp_valid_r;
   assign mbus_cmd_o   = MBUS_CMD_WIDTH'(mbus_cmd_r);
   assign mbus_addr_o  = mbus_addr_r;
   assign cbus_ack_o   = sn_ack_s;

endmodule

// File: tb/tb_mesi_isc_cpu_agent.sv
// Scoreboard bench for mesi_isc_cpu_agent: stimulus pushes expected bus/ack/resp
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_mesi_isc_cpu_agent;
   localparam int AW  = 32;
   localparam int LAT = 2;
   localparam int EV_MBUS = 0, EV_LEN = 1, EV_ACK = 2, EV_RESP = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid_i = 1'b0, req_wr_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic          req_ready_o, resp_valid_o;
   logic [2:0]    mbus_cmd_o;
   logic [AW-1:0] mbus_addr_o;
   logic          mbus_ack_i = 1'b0;
   logic [AW-1:0] cbus_addr_i = '0;
   logic [2:0]    cbus_cmd_i = 3'd0;
   logic          cbus_ack_o;
`ifdef MESI_ISC_CPU_AGENT_STATS_EN
   logic [15:0]   stat_hit_o, stat_miss_o, stat_inv_o;
`endif

   mesi_isc_cpu_agent #(.ADDR_WIDTH(AW), .SNOOP_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
      .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o),
      .mbus_cmd_o(mbus_cmd_o), .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
      .cbus_addr_i(cbus_addr_i), .cbus_cmd_i(cbus_cmd_i),
`ifdef MESI_ISC_CPU_AGENT_STATS_EN
      .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o), .stat_inv_o(stat_inv_o),
`endif
      .cbus_ack_o(cbus_ack_o)
   );

   always #5 clk = ~clk;

   typedef struct { int kind; logic [63:0] val; } ev_t;
   ev_t  exp_q[$];
   int   checks = 0, failures = 0;
   int   cyc = 0, last_ref = 0, cbus_start = 0, mb_len = 0;
   logic [34:0] mb_prev = '0;

   function automatic logic [63:0] mb(input logic [2:0] c, input logic [31:0] a);
      return {29'd0, c, a};
   endfunction

   task automatic push(input int k, input logic [63:0] v);
      ev_t e;
      e.kind = k; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_ev(input int k, input logic [63:0] v);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event kind=%0d actual=%0h required=none", k, v);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.val != v) begin
            failures++;
            $display("FAIL event actual kind=%0d val=%0h required kind=%0d val=%0h", k, v, e.kind, e.val);
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: turns DUT output activity into events and scores them
   initial forever begin
      logic [34:0] mb_cur;
      @(negedge clk);
      mb_cur = {mbus_cmd_o, mbus_addr_o};
      if (!rst) begin
         mb_prev = '0;
         mb_len  = 0;
      end else begin
         if (cbus_ack_o) begin
            check_ev(EV_ACK, 64'(cyc - cbus_start));
            last_ref = cyc;
         end
         if (resp_valid_o) check_ev(EV_RESP, 64'(cyc - last_ref));
         if (req_valid_i && req_ready_o) last_ref = cyc;
         if (mbus_cmd_o != 3'd0) begin
            if (mb_prev[34:32] == 3'd0) begin
               check_ev(EV_MBUS, 64'(mb_cur));
               mb_len = 1;
            end else begin
               chk("mbus_stable", 64'(mb_cur), 64'(mb_prev));
               mb_len++;
            end
         end else if (mb_prev[34:32] != 3'd0) begin
            check_ev(EV_LEN, 64'(mb_len));
         end
         mb_prev = mb_cur;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic wr, input logic [31:0] a);
      bit ok = 1'b0;
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_wr_i = wr; req_addr_i = a;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (req_ready_o) begin ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      if (!ok) chk("req_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic mbus_handshake();
      bit ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (mbus_cmd_o != 3'd0) begin ok = 1'b1; break; end
      end
      if (!ok) chk("mbus_cmd_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      mbus_ack_i = 1'b1;
      @(posedge clk); #1;
      mbus_ack_i = 1'b0;
   endtask

   task automatic cbus(input logic [2:0] c, input logic [31:0] a, input int hold);
      @(posedge clk); #1;
      cbus_cmd_i = c; cbus_addr_i = a; cbus_start = cyc;
      repeat (hold) @(posedge clk);
      #1;
      cbus_cmd_i = 3'd0;
      idle(LAT + 3);
   endtask

   // Miss/upgrade: broadcast held 3 cycles, then matching EN_* completes it
   task automatic miss_txn(input logic wr, input logic [31:0] a);
      push(EV_MBUS, mb(wr ? 3'd3 : 3'd4, a));
      push(EV_LEN, 64'd3);
      do_req(wr, a);
      mbus_handshake();
      push(EV_ACK, 64'(LAT));
      push(EV_RESP, 64'd1);
      cbus(wr ? 3'd3 : 3'd4, a, 1);
   endtask

   task automatic hit_txn(input logic wr, input logic [31:0] a);
      push(EV_RESP, 64'd1);
      do_req(wr, a);
      idle(3);
   endtask

   task automatic snoop_txn(input logic [2:0] c, input logic [31:0] a, input int hold);
      push(EV_ACK, 64'(LAT));
      cbus(c, a, hold);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      chk("rst_mbus_cmd", 64'(mbus_cmd_o), 64'd0);
      chk("rst_mbus_addr", 64'(mbus_addr_o), 64'd0);
      chk("rst_cbus_ack", 64'(cbus_ack_o), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("rst_req_ready", 64'(req_ready_o), 64'd0);
      idle(2);
      rst = 1'b1;
      idle(2);
      @(negedge clk);
      chk("ready_after_reset", 64'(req_ready_o), 64'd1);

      miss_txn(1'b0, 32'h104);               // load miss -> S
      miss_txn(1'b1, 32'h104);               // store on S -> upgrade -> M
      hit_txn(1'b1, 32'h104);                // store on M completes locally
      snoop_txn(3'd1, 32'h104, 4);           // held WR_SNOOP -> one ack, line I
      miss_txn(1'b0, 32'h104);               // load now misses
      miss_txn(1'b1, 32'h108);               // evicts 0x104, line M
      snoop_txn(3'd2, 32'h108, 1);           // RD_SNOOP on M -> S
      miss_txn(1'b1, 32'h108);               // store on S needs upgrade
      snoop_txn(3'd2, 32'h200, 1);           // RD_SNOOP miss, no change
      hit_txn(1'b1, 32'h108);                // still M
      snoop_txn(3'd5, 32'h108, 1);           // unknown command acked only
      hit_txn(1'b1, 32'h108);                // still M

      // Reset while waiting for EN_RD, with a snoop in flight
      push(EV_MBUS, mb(3'd4, 32'h300));
      push(EV_LEN, 64'd3);
      do_req(1'b0, 32'h300);
      mbus_handshake();
      @(posedge clk); #1;
      cbus_cmd_i = 3'd4; cbus_addr_i = 32'h300; cbus_start = cyc;
      @(posedge clk); #1;
      cbus_cmd_i = 3'd0;
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("inrst_mbus_cmd", 64'(mbus_cmd_o), 64'd0);
         chk("inrst_resp_valid", 64'(resp_valid_o), 64'd0);
         chk("inrst_cbus_ack", 64'(cbus_ack_o), 64'd0);
         chk("inrst_req_ready", 64'(req_ready_o), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("ready_after_rerelease", 64'(req_ready_o), 64'd1);

      miss_txn(1'b0, 32'h108);               // lines were invalidated by reset
      hit_txn(1'b0, 32'h108);
      hit_txn(1'b0, 32'h108);
      hit_txn(1'b0, 32'h108);
      miss_txn(1'b0, 32'h104);
      snoop_txn(3'd1, 32'h104, 1);           // invalidating hit
`ifdef MESI_ISC_CPU_AGENT_STATS_EN
      chk("stat_hit", 64'(stat_hit_o), 64'd3);
      chk("stat_miss", 64'(stat_miss_o), 64'd2);
      chk("stat_inv", 64'(stat_inv_o), 64'd1);
`endif
      idle(10);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
